// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and the
// default baud divider used by both the receiver and the transmitter.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS    = 8;
    localparam int unsigned UART_BAUD_DIVIDER = 434;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_rx_state_t;

endpackage : uart_pkg

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-low reset; flops reset to 1 (idle line)
//   d     - asynchronous input
//   q     - synchronized output, two clocks of latency
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule : uart_rx_sync

// File: rtl/uart_receiver.sv
// 8N1 UART receiver. Samples the synchronized line at mid-bit, assembles a
// byte and holds it with a level data_ready until data_ack. Sticky framing
// and overrun flags are cleared by data_ack.
// Ports:
//   clk           - system clock
//   reset         - asynchronous active-low reset
//   rx            - serial line, idle high, asynchronous to clk
//   data_ack      - consumer acknowledge, clears data_ready and both flags
//   data_out      - last received byte, stable while data_ready=1
//   data_ready    - byte available
//   framing_error - a stop bit was sampled low
//   overrun_error - a frame completed while data_ready was still set
//   busy          - receiver is inside a frame
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIVIDER = UART_BAUD_DIVIDER,
    parameter bit          MSB_FIRST    = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rx,
    input  logic                      data_ack,
    output logic [UART_DATA_BITS-1:0] data_out,
    output logic                      data_ready,
    output logic                      framing_error,
    output logic                      overrun_error,
    output logic                      busy
);

    localparam int unsigned CLKS = BAUD_DIVIDER + 1;
    localparam int unsigned HALF = CLKS / 2;
    localparam int unsigned CW   = (CLKS > 1) ? $clog2(CLKS) : 1;

    logic rx_s;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    uart_rx_state_t state_d, state_q;
    logic [CW-1:0]             baud_cnt_d, baud_cnt_q;
    logic [2:0]                bit_cnt_d, bit_cnt_q;
    logic [UART_DATA_BITS-1:0] shreg_d, shreg_q;
    logic [UART_DATA_BITS-1:0] data_out_d, data_out_q;
    logic                      data_ready_d, data_ready_q;
    logic                      framing_error_d, framing_error_q;
    logic                      overrun_error_d, overrun_error_q;
    // Set after a low stop bit: start detection stays disarmed until the
    // line returns high, so a break does not retrigger every cycle.
    logic                      wait_high_d, wait_high_q;

    always_comb begin
        state_d         = state_q;
        baud_cnt_d      = baud_cnt_q;
        bit_cnt_d       = bit_cnt_q;
        shreg_d         = shreg_q;
        data_out_d      = data_out_q;
        wait_high_d     = wait_high_q;
        // Ack clears the old status first; a frame completing in the same
        // cycle then sees data_ready=0 and loads normally.
        data_ready_d    = data_ack ? 1'b0 : data_ready_q;
        framing_error_d = data_ack ? 1'b0 : framing_error_q;
        overrun_error_d = data_ack ? 1'b0 : overrun_error_q;

        unique case (state_q)
            IDLE: begin
                if (wait_high_q) begin
                    if (rx_s) wait_high_d = 1'b0;
                end else if (!rx_s) begin
                    state_d    = START;
                    baud_cnt_d = '0;
                end
            end
            START: begin
                if (baud_cnt_q == CW'(HALF - 1)) begin
                    if (!rx_s) begin
                        state_d    = DATA;
                        baud_cnt_d = '0;
                        bit_cnt_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_cnt_q == CW'(CLKS - 1)) begin
                    baud_cnt_d = '0;
                    if (MSB_FIRST) shreg_d = {shreg_q[UART_DATA_BITS-2:0], rx_s};
                    else           shreg_d = {rx_s, shreg_q[UART_DATA_BITS-1:1]};
                    if (bit_cnt_q == 3'd7) state_d   = STOP;
                    else                   bit_cnt_d = bit_cnt_q + 1'b1;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_cnt_q == CW'(CLKS - 1)) begin
                    baud_cnt_d = '0;
                    state_d    = IDLE;
                    if (rx_s) begin
                        if (!data_ready_d) begin
                            data_out_d   = shreg_q;
                            data_ready_d = 1'b1;
                        end else begin
                            overrun_error_d = 1'b1;
                        end
                    end else begin
                        framing_error_d = 1'b1;
                        wait_high_d     = 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            baud_cnt_q      <= '0;
            bit_cnt_q       <= '0;
            shreg_q         <= '0;
            data_out_q      <= '0;
            data_ready_q    <= 1'b0;
            framing_error_q <= 1'b0;
            overrun_error_q <= 1'b0;
            wait_high_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            baud_cnt_q      <= baud_cnt_d;
            bit_cnt_q       <= bit_cnt_d;
            shreg_q         <= shreg_d;
            data_out_q      <= data_out_d;
            data_ready_q    <= data_ready_d;
            framing_error_q <= framing_error_d;
            overrun_error_q <= overrun_error_d;
            wait_high_q     <= wait_high_d;
        end
    end

    assign data_out      = data_out_q;
    assign data_ready    = data_ready_q;
    assign framing_error = framing_error_q;
    assign overrun_error = overrun_error_q;
    assign busy          = (state_q != IDLE);

endmodule : uart_receiver

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver with a 16-clock bit period. The line is
// driven directly from the bench, MSB first, changing on the falling edge.
module tb_uart_receiver;

    localparam int unsigned BIT_CLKS = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       data_ack;
    logic [7:0] data_out;
    logic       data_ready;
    logic       framing_error;
    logic       overrun_error;
    logic       busy;

    int unsigned checks = 0;
    int unsigned errors = 0;

    uart_receiver #(
        .BAUD_DIVIDER (15),
        .MSB_FIRST    (1'b1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx            (rx),
        .data_ack      (data_ack),
        .data_out      (data_out),
        .data_ready    (data_ready),
        .framing_error (framing_error),
        .overrun_error (overrun_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic hold_line(input logic level, input int unsigned clks);
        rx = level;
        repeat (clks) @(negedge clk);
    endtask

    // Full frame: start, 8 data bits MSB first, stop bit at the given level,
    // then the line is returned high.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        hold_line(1'b0, BIT_CLKS);
        for (int i = 7; i >= 0; i--) hold_line(b[i], BIT_CLKS);
        hold_line(stop_bit, BIT_CLKS);
        rx = 1'b1;
    endtask

    task automatic ack();
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
        @(negedge clk);
    endtask

    logic [7:0] loop_bytes [4] = '{8'h3C, 8'h00, 8'hFF, 8'h81};

    initial begin
        rx       = 1'b1;
        data_ack = 1'b0;
        reset    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data",  data_out, 8'h00);
        check("rst_ready", data_ready, 1'b0);
        check("rst_fe",    framing_error, 1'b0);
        check("rst_oe",    overrun_error, 1'b0);
        check("rst_busy",  busy, 1'b0);
        reset = 1'b1;
        repeat (20) @(negedge clk);

        // Basic frame
        send_frame(8'hA5, 1'b1);
        check("a5_data",  data_out, 8'hA5);
        check("a5_ready", data_ready, 1'b1);
        check("a5_fe",    framing_error, 1'b0);
        check("a5_oe",    overrun_error, 1'b0);
        check("a5_busy",  busy, 1'b0);
        ack();
        check("a5_ack_ready", data_ready, 1'b0);

        // Several patterns, back-to-back with ack between
        foreach (loop_bytes[i]) begin
            send_frame(loop_bytes[i], 1'b1);
            check("loop_data",  data_out, loop_bytes[i]);
            check("loop_ready", data_ready, 1'b1);
            ack();
        end

        // Short glitch on the line is rejected
        hold_line(1'b0, 5);
        check("glitch_busy_hi", busy, 1'b1);
        hold_line(1'b1, 20);
        check("glitch_busy_lo", busy, 1'b0);
        check("glitch_ready",   data_ready, 1'b0);
        check("glitch_fe",      framing_error, 1'b0);
        check("glitch_oe",      overrun_error, 1'b0);

        // Low stop bit
        send_frame(8'h55, 1'b0);
        repeat (4) @(negedge clk);
        check("fe_flag",  framing_error, 1'b1);
        check("fe_ready", data_ready, 1'b0);
        check("fe_data",  data_out, 8'h81);
        ack();
        check("fe_clear", framing_error, 1'b0);

        // Overrun: second frame arrives before ack
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        check("ovr_data",  data_out, 8'h11);
        check("ovr_ready", data_ready, 1'b1);
        check("ovr_flag",  overrun_error, 1'b1);
        check("ovr_fe",    framing_error, 1'b0);
        ack();
        check("ovr_clr_ready", data_ready, 1'b0);
        check("ovr_clr_oe",    overrun_error, 1'b0);

        // Reset in the middle of a frame (0xF0: start, then first two ones)
        hold_line(1'b0, BIT_CLKS);
        hold_line(1'b1, 2 * BIT_CLKS);
        check("mid_busy", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("mid_rst_data",  data_out, 8'h00);
        check("mid_rst_ready", data_ready, 1'b0);
        check("mid_rst_busy",  busy, 1'b0);
        check("mid_rst_fe",    framing_error, 1'b0);
        check("mid_rst_oe",    overrun_error, 1'b0);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'h0F, 1'b1);
        check("post_data",  data_out, 8'h0F);
        check("post_ready", data_ready, 1'b1);
        check("post_fe",    framing_error, 1'b0);
        check("post_oe",    overrun_error, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_receiver
